// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [XLEN-1:0] HALT_INSN = 32'h0000_0063;
  localparam logic [XLEN-1:0] MRET_INSN = 32'h3020_0073;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with single-cycle flush.
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencing, redirect/trap/mret control, fetch buffer to decode.
// Optional macro IFU_HALT_DETECT_EN stops fetching after a beq x0,x0,0 self-loop.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_004C,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  output logic [31:0] mepc,
  output logic        halted
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  mepc_q, mepc_d;
  logic [31:0]  last_pc_q, last_pc_d;
  logic         push, pop, flush, full, empty, halt_block;
  fetch_entry_t head, wr_entry;

  ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign imem_pc  = fetch_pc_q;
  assign mepc     = mepc_q;
  assign if_valid = !empty;
  assign if_instr = empty ? NOP_INSN : head.instr;
  assign if_pc    = empty ? last_pc_q : head.pc;
  assign wr_entry = '{pc: fetch_pc_q, instr: imem_instr};

  // Priority: trap > mret > redirect > sequential fetch.
  always_comb begin
    pop        = if_valid && if_ready;
    flush      = trap_req || mret_req || (redirect_valid && !halt_block);
    push       = !flush && !halt_block && (!full || pop);
    fetch_pc_d = fetch_pc_q;
    mepc_d     = mepc_q;
    if (trap_req) begin
      fetch_pc_d = TRAP_VEC;
      mepc_d     = trap_pc;
    end else if (mret_req) begin
      fetch_pc_d = mepc_q;
    end else if (redirect_valid && !halt_block) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    last_pc_d = empty ? last_pc_q : head.pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      mepc_q     <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mepc_q     <= mepc_d;
      last_pc_q  <= last_pc_d;
    end
  end

`ifdef IFU_HALT_DETECT_EN
  logic halted_q, halted_d;

  // The halting entry itself is still pushed; only later fetches are blocked.
  always_comb begin
    halted_d = halted_q;
    if (trap_req || mret_req)                halted_d = 1'b0;
    else if (push && imem_instr == HALT_INSN) halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign halt_block = halted_q;
  assign halted     = halted_q;
`else
  assign halt_block = 1'b0;
  assign halted     = 1'b0;
`endif

endmodule
